// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 2-bit ALU among NUM_REQ requesters and returns a registered, id-tagged 4-bit result.
// Optional macro ALU_ARB_BYPASS_EN lets a new op be accepted in the same cycle the held result is consumed.

module alu_arbiter_alu (
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    input  logic [1:0] i_sel,
    output logic [3:0] o_res
);
    always_comb begin
        case (i_sel)
            2'b11:   o_res = {2'b00, i_a} * {2'b00, i_b};
            2'b10:   o_res = {2'b00, i_a} + {2'b00, i_b};
            2'b01:   o_res = {2'b00, ~(i_a & i_b)};
            default: o_res = {2'b00, ~i_a};
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [2*NUM_REQ-1:0] req_a,
    input  logic [2*NUM_REQ-1:0] req_b,
    input  logic [2*NUM_REQ-1:0] req_select,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id
);
    localparam logic [ID_W:0]   NREQ = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ-1);

    typedef enum logic {IDLE, RESP} state_t;

    typedef struct packed {
        logic [3:0]      data;
        logic [ID_W-1:0] id;
    } rsp_t;

    state_t          r_state;
    rsp_t            r_rsp;
    logic            r_rsp_valid;
    logic [ID_W-1:0] r_rr_ptr;

    logic                    w_accept_en;
    logic                    w_found;
    logic                    w_xfer;
    logic [ID_W-1:0]         w_win;
    logic [ID_W-1:0]         w_ptr_nxt;
    logic [ID_W:0]           w_idx;
    logic [NUM_REQ-1:0][1:0] w_a;
    logic [NUM_REQ-1:0][1:0] w_b;
    logic [NUM_REQ-1:0][1:0] w_sel;
    logic [1:0]              w_op_a;
    logic [1:0]              w_op_b;
    logic [1:0]              w_op_sel;
    logic [3:0]              w_alu_res;

    assign w_a   = req_a;
    assign w_b   = req_b;
    assign w_sel = req_select;

`ifdef ALU_ARB_BYPASS_EN
    // Consuming the held result frees the output register for a same-cycle accept.
    assign w_accept_en = rst_n && ((r_state == IDLE) || rsp_ready);
`else
    assign w_accept_en = rst_n && (r_state == IDLE);
`endif

    // Walk indices from r_rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
            if (w_idx >= NREQ)
                w_idx = w_idx - NREQ;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_found && req_valid[i] && (w_idx == (ID_W+1)'(i))) begin
                    w_found = 1'b1;
                    w_win   = ID_W'(i);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = w_accept_en && w_found && (w_win == ID_W'(g));
    end

    always_comb begin
        w_op_a   = '0;
        w_op_b   = '0;
        w_op_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == ID_W'(i)) begin
                w_op_a   = w_a[i];
                w_op_b   = w_b[i];
                w_op_sel = w_sel[i];
            end
        end
    end

    alu_arbiter_alu u_alu (
        .i_a   (w_op_a),
        .i_b   (w_op_b),
        .i_sel (w_op_sel),
        .o_res (w_alu_res)
    );

    assign w_xfer    = w_accept_en && w_found;
    assign w_ptr_nxt = (w_win == LAST) ? '0 : w_win + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp.data  <= w_alu_res;
            r_rsp.id    <= w_win;
            r_rr_ptr    <= w_ptr_nxt;
        end else if ((r_state == RESP) && rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp.data;
    assign rsp_id    = r_rsp.id;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; expectations follow ALU_ARB_BYPASS_EN when it is defined.

module tb_alu_arbiter;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [2*N-1:0] req_select;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [3:0]     rsp_data;
    logic [1:0]     rsp_id;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_select (req_select),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
        req_valid[i]       = 1'b1;
        req_a[2*i +: 2]      = a;
        req_b[2*i +: 2]      = b;
        req_select[2*i +: 2] = s;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        set_req(0, 2'd1, 2'd1, 2'b10);
        #1;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else n_pass++;
        tick;
        tick;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 4'd0) $display("FAIL reset_data: got %0d want 0", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL reset_id: got %0d want 0", rsp_id); else n_pass++;
        clr_req(0);
        rst_n = 1'b1;
    endtask

    task automatic test_mul;
        set_req(0, 2'd3, 2'd3, 2'b11);
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL mul_ready: got %b want 0001", req_ready); else n_pass++;
        tick;
        clr_req(0);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL mul_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 4'd9) $display("FAIL mul_data: got %0d want 9", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL mul_id: got %0d want 0", rsp_id); else n_pass++;
        rsp_ready = 1'b1;
        tick;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL mul_drain: got %b want 0", rsp_valid); else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_hold;
        set_req(1, 2'd3, 2'd2, 2'b10);
        #1;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL hold_grant: got %b want 0010", req_ready); else n_pass++;
        tick;
        clr_req(1);
        set_req(0, 2'd1, 2'd1, 2'b10);
        #1;
        for (int k = 0; k < 5; k++) begin
            n_total++; if (rsp_valid !== 1'b1) $display("FAIL hold_valid%0d: got %b want 1", k, rsp_valid); else n_pass++;
            n_total++; if (rsp_data !== 4'd5) $display("FAIL hold_data%0d: got %0d want 5", k, rsp_data); else n_pass++;
            n_total++; if (rsp_id !== 2'd1) $display("FAIL hold_id%0d: got %0d want 1", k, rsp_id); else n_pass++;
            n_total++; if (req_ready !== 4'b0000) $display("FAIL hold_ready%0d: got %b want 0000", k, req_ready); else n_pass++;
            tick;
        end
        rsp_ready = 1'b1;
        #1;
`ifdef ALU_ARB_BYPASS_EN
        n_total++; if (req_ready !== 4'b0001) $display("FAIL bypass_grant: got %b want 0001", req_ready); else n_pass++;
        tick;
`else
        n_total++; if (req_ready !== 4'b0000) $display("FAIL consume_ready: got %b want 0000", req_ready); else n_pass++;
        tick;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL consume_idle: got %b want 0", rsp_valid); else n_pass++;
        #1;
        n_total++; if (req_ready !== 4'b0001) $display("FAIL idle_grant: got %b want 0001", req_ready); else n_pass++;
        tick;
`endif
        clr_req(0);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL next_valid: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 4'd2) $display("FAIL next_data: got %0d want 2", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd0) $display("FAIL next_id: got %0d want 0", rsp_id); else n_pass++;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_ops;
        set_req(1, 2'd3, 2'd3, 2'b10);
        #1;
        n_total++; if (req_ready !== 4'b0010) $display("FAIL add_ready: got %b want 0010", req_ready); else n_pass++;
        tick;
        clr_req(1);
        n_total++; if (rsp_data !== 4'd6) $display("FAIL add_data: got %0d want 6", rsp_data); else n_pass++;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        set_req(2, 2'b10, 2'b11, 2'b01);
        #1;
        n_total++; if (req_ready !== 4'b0100) $display("FAIL nand_ready: got %b want 0100", req_ready); else n_pass++;
        tick;
        clr_req(2);
        n_total++; if (rsp_data !== 4'b0001) $display("FAIL nand_data: got %0d want 1", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd2) $display("FAIL nand_id: got %0d want 2", rsp_id); else n_pass++;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        set_req(3, 2'b01, 2'b00, 2'b00);
        #1;
        n_total++; if (req_ready !== 4'b1000) $display("FAIL not_ready: got %b want 1000", req_ready); else n_pass++;
        tick;
        clr_req(3);
        n_total++; if (rsp_data !== 4'b0010) $display("FAIL not_data: got %0d want 2", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd3) $display("FAIL not_id: got %0d want 3", rsp_id); else n_pass++;
        rsp_ready = 1'b1;
        tick;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL ops_drain: got %b want 0", rsp_valid); else n_pass++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [3:0] exp_d  [5] = '{4'd9, 4'd3, 4'd2, 4'd1, 4'd9};
        int nr   = 0;
        int cnt8 = 0;
        rsp_ready = 1'b1;
        set_req(0, 2'd3, 2'd3, 2'b11);
        set_req(1, 2'd1, 2'd2, 2'b10);
        set_req(2, 2'b01, 2'b01, 2'b01);
        set_req(3, 2'b10, 2'b00, 2'b00);
        for (int e = 1; e <= 12; e++) begin
            tick;
            if (rsp_valid === 1'b1) begin
                if (nr < 5) begin
                    n_total++; if (rsp_id !== exp_id[nr]) $display("FAIL rr_id%0d: got %0d want %0d", nr, rsp_id, exp_id[nr]); else n_pass++;
                    n_total++; if (rsp_data !== exp_d[nr]) $display("FAIL rr_data%0d: got %0d want %0d", nr, rsp_data, exp_d[nr]); else n_pass++;
                end
                if (e <= 8) cnt8++;
                nr++;
            end
        end
        n_total++; if (nr < 5) $display("FAIL rr_count: got %0d want >=5", nr); else n_pass++;
`ifdef ALU_ARB_BYPASS_EN
        n_total++; if (cnt8 !== 8) $display("FAIL rr_rate: got %0d want 8 results in 8 cycles", cnt8); else n_pass++;
`else
        n_total++; if (cnt8 !== 4) $display("FAIL rr_rate: got %0d want 4 results in 8 cycles", cnt8); else n_pass++;
`endif
        req_valid = '0;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        set_req(1, 2'd3, 2'd2, 2'b10);
        tick;
        clr_req(1);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", rsp_valid); else n_pass++;
        rst_n = 1'b0;
        set_req(2, 2'd2, 2'd3, 2'b11);
        set_req(3, 2'd3, 2'd3, 2'b10);
        #1;
        n_total++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", req_ready); else n_pass++;
        tick;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 4'd0) $display("FAIL mid_data: got %0d want 0", rsp_data); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++; if (req_ready !== 4'b0100) $display("FAIL mid_grant: got %b want 0100", req_ready); else n_pass++;
        tick;
        clr_req(2);
        n_total++; if (rsp_data !== 4'd6) $display("FAIL mid_data2: got %0d want 6", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd2) $display("FAIL mid_id2: got %0d want 2", rsp_id); else n_pass++;
        rsp_ready = 1'b1;
`ifdef ALU_ARB_BYPASS_EN
        tick;
`else
        tick;
        tick;
`endif
        clr_req(3);
        n_total++; if (rsp_valid !== 1'b1) $display("FAIL mid_valid3: got %b want 1", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 4'd6) $display("FAIL mid_data3: got %0d want 6", rsp_data); else n_pass++;
        n_total++; if (rsp_id !== 2'd3) $display("FAIL mid_id3: got %0d want 3", rsp_id); else n_pass++;
        tick;
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_select = '0;
        test_reset;
        test_mul;
        test_hold;
        test_ops;
        test_round_robin;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
